uoram_req_arbiter: RTL

Round-robin arbiter that shares one unified-ORAM frontend command/data/return interface between `NumReq` independent requesters. It sits between the network-side clients and the frontend controller's `CmdIn`/`DataIn`/`ReturnData` ports. For each granted write it sequences the block's data beats from the owning requester. For each granted read it records the requester ID so returned beats are routed back in order.

---
 rtl/uoram_req_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/uoram_req_arbiter.sv
// Round-robin arbiter sharing one unified-ORAM frontend command/data/return port among NumReq
// requesters. Define UORAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module uoram_req_arbiter #(
    parameter int unsigned NumReq            = 2,
    parameter int unsigned ORAMU             = 32,
    parameter int unsigned FEDWidth          = 64,
    parameter int unsigned BlkSize_FEDChunks = 8,
    parameter int unsigned TagDepth          = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NumReq-1:0]          ReqCmdValid,
    output logic [NumReq-1:0]          ReqCmdReady,
    input  logic [2*NumReq-1:0]        ReqCmd,
    input  logic [ORAMU*NumReq-1:0]    ReqAddr,
    input  logic [NumReq-1:0]          ReqDataValid,
    output logic [NumReq-1:0]          ReqDataReady,
    input  logic [FEDWidth*NumReq-1:0] ReqData,
    output logic [NumReq-1:0]          ReqRetValid,
    input  logic [NumReq-1:0]          ReqRetReady,
    output logic [FEDWidth-1:0]        ReqRetData,
    output logic                       CmdInValid,
    input  logic                       CmdInReady,
    output logic [1:0]                 CmdIn,
    output logic [ORAMU-1:0]           ProgAddrIn,
    output logic                       DataInValid,
    input  logic                       DataInReady,
    output logic [FEDWidth-1:0]        DataIn,
    input  logic                       ReturnDataValid,
    output logic                       ReturnDataReady,
    input  logic [FEDWidth-1:0]        ReturnData,
    output logic                       ArbError
);
    localparam int unsigned IdW   = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned BeatW = $clog2(BlkSize_FEDChunks) + 1;
    localparam int unsigned PtrW  = $clog2(TagDepth);
    localparam int unsigned CntW  = PtrW + 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BlkSize_FEDChunks - 1);

    localparam logic [1:0] BECMD_Update = 2'd0;
    localparam logic [1:0] BECMD_Append = 2'd1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCmd  = 2'd1;
    localparam logic [1:0] StData = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IdW-1:0]   owner_q, owner_d, last_q, last_d, winner;
    logic [1:0]       cmd_q, cmd_d, sel_cmd;
    logic [ORAMU-1:0] addr_q, addr_d, sel_addr;
    logic [BeatW-1:0] beat_q, beat_d, ret_cnt_q, ret_cnt_d;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q, err_q, run_q;
    logic [IdW-1:0]   tag_mem_q [TagDepth];
    logic [IdW-1:0]   head;
    logic             grant, push, pop, empty, ret_hs;

    // run_q keeps every combinational handshake output at 0 while in reset.
    assign grant      = run_q && (state_q == StIdle) && (|ReqCmdValid) && !full_q;
    assign empty      = (count_q == '0);
    assign head       = tag_mem_q[rd_ptr_q];
    assign ret_hs     = run_q && !empty && ReturnDataValid && ReturnDataReady;
    assign pop        = ret_hs && (ret_cnt_q == LastBeat);
    assign CmdInValid = (state_q == StCmd);
    assign CmdIn      = cmd_q;
    assign ProgAddrIn = addr_q;
    assign ArbError   = err_q;
    assign ReqRetData = ReturnData;

`ifdef UORAM_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (ReqCmdValid[i]) winner = IdW'(i);
        end
    end
`else
    logic found;
    int   rr_idx;
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = 0;
        for (int i = 0; i < int'(NumReq); i++) begin
            rr_idx = int'(last_q) + 1 + i;
            if (rr_idx >= int'(NumReq)) rr_idx = rr_idx - int'(NumReq);
            for (int j = 0; j < int'(NumReq); j++) begin
                if (!found && (j == rr_idx) && ReqCmdValid[j]) begin
                    found  = 1'b1;
                    winner = IdW'(j);
                end
            end
        end
    end
`endif

    always_comb begin
        sel_cmd      = '0;
        sel_addr     = '0;
        ReqCmdReady  = '0;
        DataInValid  = 1'b0;
        ReqDataReady = '0;
        DataIn       = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (winner == IdW'(i)) begin
                sel_cmd        = ReqCmd[2*i +: 2];
                sel_addr       = ReqAddr[ORAMU*i +: ORAMU];
                ReqCmdReady[i] = grant;
            end
            if ((state_q == StData) && (owner_q == IdW'(i))) begin
                DataInValid     = ReqDataValid[i];
                ReqDataReady[i] = DataInReady;
                DataIn          = ReqData[FEDWidth*i +: FEDWidth];
            end
        end
    end

    // Return path: head tag steers valid; with no tag outstanding the beat is sunk.
    always_comb begin
        ReqRetValid     = '0;
        ReturnDataReady = 1'b0;
        if (run_q) begin
            if (empty) begin
                ReturnDataReady = 1'b1;
            end else begin
                for (int i = 0; i < int'(NumReq); i++) begin
                    if (head == IdW'(i)) begin
                        ReqRetValid[i]  = ReturnDataValid;
                        ReturnDataReady = ReqRetReady[i];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    owner_d = winner;
                    last_d  = winner;
                    cmd_d   = sel_cmd;
                    addr_d  = sel_addr;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (CmdInReady) begin
                    if ((cmd_q == BECMD_Update) || (cmd_q == BECMD_Append)) begin
                        beat_d  = '0;
                        state_d = StData;
                    end else begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (DataInValid && DataInReady) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        ret_cnt_d = ret_cnt_q;
        if (ret_hs) ret_cnt_d = pop ? '0 : ret_cnt_q + 1'b1;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            run_q     <= 1'b0;
            state_q   <= StIdle;
            owner_q   <= '0;
            last_q    <= IdW'(NumReq - 1);
            cmd_q     <= '0;
            addr_q    <= '0;
            beat_q    <= '0;
            ret_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            ret_cnt_q <= ret_cnt_d;
            count_q   <= count_d;
            full_q    <= (count_d == CntW'(TagDepth));
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (run_q && empty && ReturnDataValid) err_q <= 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) tag_mem_q[wr_ptr_q] <= owner_q;
    end
endmodule
